// File: rtl/inc_arb_pkg.sv
// Shared constants for inc_unit_arbiter: FSM state encodings, default sizing
// and the 4-bit increment datapath.
package inc_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int IDW_DEF  = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Returns {carry, sum}; carry is set only for an all-ones operand.
  function automatic logic [4:0] inc4(input logic [3:0] op);
    return {&op, op + 4'd1};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after
// ptr_i (wrapping) wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_id_o,
  output logic            any_req_o
);

  logic           found;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_i + IDW'(k);
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        gnt_o[idx]    = 1'b1;
        gnt_id_o      = idx;
      end
    end
  end

  assign any_req_o = |req_i;

endmodule

// File: rtl/inc_unit_arbiter.sv
// Round-robin sequencer sharing one 4-bit incrementer among NREQ requesters.
// Build option INC_ARB_FASTPATH_EN removes EXEC and registers the sum in IDLE.
//
// state | meaning
// IDLE  | waiting for a request; grants and latches the winner
// EXEC  | latched operand through the incrementer (absent in fast-path build)
// RESP  | response held on rsp_* until rsp_ready
module inc_unit_arbiter
  import inc_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_data,
  output logic              rsp_carry,
  input  logic              rsp_ready,
  output logic              busy
);

  logic [1:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [3:0]      sum_q, sum_d;
  logic            carry_q, carry_d;
`ifndef INC_ARB_FASTPATH_EN
  logic [3:0]      op_q, op_d;
`endif

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_id;
  logic            any_req;
  logic [3:0]      win_data;
  logic [4:0]      inc_res;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .any_req_o (any_req)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_data = win_data | (req_data[4*i +: 4] & {4{gnt[i]}});
    end
  end

`ifdef INC_ARB_FASTPATH_EN
  assign inc_res = inc4(win_data);
`else
  assign inc_res = inc4(op_q);
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifndef INC_ARB_FASTPATH_EN
    op_d    = op_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          id_d = gnt_id;
`ifdef INC_ARB_FASTPATH_EN
          {carry_d, sum_d} = inc_res;
          state_d          = ST_RESP;
`else
          op_d    = win_data;
          state_d = ST_EXEC;
`endif
        end
      end
`ifndef INC_ARB_FASTPATH_EN
      ST_EXEC: begin
        {carry_d, sum_d} = inc_res;
        state_d          = ST_RESP;
      end
`endif
      ST_RESP: begin
        if (rsp_ready) begin
          ptr_d   = id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifndef INC_ARB_FASTPATH_EN
      op_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifndef INC_ARB_FASTPATH_EN
      op_q    <= op_d;
`endif
    end
  end

  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = sum_q;
  assign rsp_carry = carry_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_inc_unit_arbiter.sv
// Self-checking bench for inc_unit_arbiter against a transaction-level model
// (round-robin winner search, operand+1 arithmetic, fixed response latency).
module tb_inc_unit_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef INC_ARB_FASTPATH_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [4*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_data;
  logic              rsp_carry;
  logic              rsp_ready = 1'b0;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_ptr = 0;

  inc_unit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round-robin rule: first valid requester at ptr, ptr+1, ... modulo NREQ.
  function automatic int model_winner(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NREQ-1:0] g;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, busy} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %b required 0", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, busy}); end
    rst_n = 1'b1; model_ptr = 0;
    step();
    // move ptr away from 0 first so the post-reset grant is meaningful
    req_valid = 4'b0010; req_data = 16'($urandom);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL reset_pre_grant: got %b required 0010", req_ready); end
    step(); req_valid = '0;
    repeat (LAT) step();
    req_valid = 4'b1000;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL reset_pre_grant3: got %b required 1000", req_ready); end
    step(); req_valid = '0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, busy} !== '0) begin n_fail++; $display("FAIL reset_midtxn_outputs: got %b required 0", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, busy}); end
    #1 rst_n = 1'b1; model_ptr = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_rsp: rsp_valid %b busy %b required 0 0", rsp_valid, busy); end
      step();
    end
    req_valid = '1;
    @(negedge clk);
    g = onehot(model_winner('1, model_ptr));
    n_checks++; if (req_ready !== g) begin n_fail++; $display("FAIL reset_next_grant: got %b required %b", req_ready, g); end
    step(); req_valid = '0;
    repeat (LAT) step();
    model_ptr = (model_winner('1, model_ptr) + 1) % NREQ;
  endtask

  task automatic test_single();
    int r, got;
    logic [3:0] op;
    logic [NREQ-1:0] v;
    for (int n = 0; n < 6; n++) begin
      r  = (n == 0) ? 0 : int'($urandom_range(0, NREQ-1));
      op = (n == 0) ? 4'h5 : 4'($urandom_range(0, 15));
      v = onehot(r);
      req_valid = v; req_data = 16'($urandom); req_data[4*r +: 4] = op; rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (req_ready !== v) begin n_fail++; $display("FAIL single_grant: got %b required %b", req_ready, v); end
      step(); req_valid = '0;
      got = 0;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (rsp_valid) begin got = i; break; end
        step();
      end
      n_checks++; if (got != LAT) begin n_fail++; $display("FAIL single_latency: got %0d required %0d", got, LAT); end
      n_checks++; if (rsp_id !== IDW'(r) || rsp_data !== 4'((op + 1) % 16) || rsp_carry !== (op == 4'hF)) begin n_fail++; $display("FAIL single_rsp: id %0d data %h carry %b required %0d %h %b", rsp_id, rsp_data, rsp_carry, r, 4'((op + 1) % 16), op == 4'hF); end
      step(); model_ptr = (r + 1) % NREQ;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b required 0", busy); end
      step();
    end
  endtask

  task automatic test_wrap();
    int got;
    req_valid = 4'b0100; req_data = 16'h0F00 | 16'($urandom_range(0, 255)); rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_grant: got %b required 0100", req_ready); end
    step(); req_valid = '0;
    got = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = i; break; end
      step();
    end
    n_checks++; if (got != LAT || rsp_id !== 2'd2 || rsp_data !== 4'h0 || rsp_carry !== 1'b1) begin n_fail++; $display("FAIL wrap_rsp: lat %0d id %0d data %h carry %b required %0d 2 0 1", got, rsp_id, rsp_data, rsp_carry, LAT); end
    step(); model_ptr = 3;
  endtask

  task automatic test_fairness();
    int w, prev, found, got;
    logic [3:0] op;
    rst_n = 1'b0; #2 rst_n = 1'b1; model_ptr = 0;
    step();
    req_valid = '1; rsp_ready = 1'b1; prev = -1;
    for (int n = 0; n < 5; n++) begin
      req_data = 16'($urandom);
      found = 0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (|req_ready) begin found = 1; break; end
        step();
      end
      w = model_winner('1, model_ptr);
      n_checks++; if (found == 0 || req_ready !== onehot(w)) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b required %b", n, req_ready, onehot(w)); end
      if (prev >= 0) begin
        n_checks++; if (cyc - prev != LAT + 1) begin n_fail++; $display("FAIL fair_interval[%0d]: got %0d required %0d", n, cyc - prev, LAT + 1); end
      end
      prev = cyc;
      op = req_data[4*w +: 4];
      step();
      got = 0;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (rsp_valid) begin got = i; break; end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL fair_inflight_ready: got %b required 0", req_ready); end
        step();
      end
      n_checks++; if (got != LAT || rsp_id !== IDW'(w) || rsp_data !== 4'((op + 1) % 16)) begin n_fail++; $display("FAIL fair_rsp[%0d]: lat %0d id %0d data %h required %0d %0d %h", n, got, rsp_id, rsp_data, LAT, w, 4'((op + 1) % 16)); end
      step(); model_ptr = (w + 1) % NREQ;
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    int w, w2, got;
    logic [3:0] op;
    req_valid = '1; req_data = 16'($urandom); rsp_ready = 1'b0;
    @(negedge clk);
    w = model_winner('1, model_ptr);
    n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL bp_grant: got %b required %b", req_ready, onehot(w)); end
    op = req_data[4*w +: 4];
    step();
    got = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (rsp_valid) begin got = i; break; end
      step();
    end
    n_checks++; if (got != LAT) begin n_fail++; $display("FAIL bp_latency: got %0d required %0d", got, LAT); end
    for (int s = 0; s < 5; s++) begin
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(w) || rsp_data !== 4'((op + 1) % 16) || rsp_carry !== (op == 4'hF) || req_ready !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: v %b id %0d data %h carry %b ready %b busy %b required 1 %0d %h %b 0 1", s, rsp_valid, rsp_id, rsp_data, rsp_carry, req_ready, busy, w, 4'((op + 1) % 16), op == 4'hF); end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    step(); model_ptr = (w + 1) % NREQ;
    @(negedge clk);
    w2 = model_winner('1, model_ptr);
    n_checks++; if (req_ready !== onehot(w2)) begin n_fail++; $display("FAIL bp_next_grant: got %b required %b", req_ready, onehot(w2)); end
    step(); req_valid = '0;
    repeat (LAT) step();
    model_ptr = (w2 + 1) % NREQ;
  endtask

  task automatic test_random();
    int w, got, stall;
    logic [3:0] op;
    logic [NREQ-1:0] v;
    for (int n = 0; n < 20; n++) begin
      v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      stall = int'($urandom_range(0, 3));
      req_valid = v; req_data = 16'($urandom); rsp_ready = (stall == 0);
      @(negedge clk);
      w = model_winner(v, model_ptr);
      n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL rand_grant[%0d]: valid %b ptr %0d got %b required %b", n, v, model_ptr, req_ready, onehot(w)); end
      op = req_data[4*w +: 4];
      step();
      got = 0;
      for (int i = 1; i <= 8; i++) begin
        req_valid = NREQ'($urandom);
        @(negedge clk);
        if (rsp_valid) begin got = i; break; end
        step();
      end
      n_checks++; if (got != LAT) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d required %0d", n, got, LAT); end
      for (int s = 0; s <= stall; s++) begin
        n_checks++; if (rsp_id !== IDW'(w) || rsp_data !== 4'((op + 1) % 16) || rsp_carry !== (op == 4'hF) || req_ready !== '0) begin n_fail++; $display("FAIL rand_rsp[%0d]: id %0d data %h carry %b ready %b required %0d %h %b 0", n, rsp_id, rsp_data, rsp_carry, req_ready, w, 4'((op + 1) % 16), op == 4'hF); end
        if (s < stall) begin
          @(posedge clk);
          #1 req_valid = NREQ'($urandom);
          @(negedge clk);
        end
      end
      rsp_ready = 1'b1; req_valid = '0;
      step(); model_ptr = (w + 1) % NREQ;
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_fairness();
    test_backpressure();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inc_unit_arbiter.md
# inc_unit_arbiter

Round-robin arbiter and sequencer that shares a single 4-bit increment-by-one datapath among NREQ requesters. Each requester offers a 4-bit operand through a valid/ready handshake. The block grants one requester at a time, sequences the operand through the incrementer, and returns the sum, carry-out and requester ID on a shared response channel with backpressure. It sits between the per-unit request ports and the shared increment datapath.

## Interface
- NREQ, 4: number of requesters; power of 2, range 2..8
- IDW, 2: requester ID width, equal to log2(NREQ)
- clk  input  1  system clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_data  input  4*NREQ  per-requester operand; requester i uses bits [4i+3:4i]
- req_ready  output  NREQ  one-hot accept pulse to the granted requester
- rsp_valid  output  1  response valid
- rsp_id  output  IDW  ID of the requester being answered
- rsp_data  output  4  operand + 1, modulo 16
- rsp_carry  output  1  carry-out; 1 only when the operand was 4'hF
- rsp_ready  input  1  response consumer ready
- busy  output  1  high in any state except IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, select the winner by round-robin starting at pointer ptr.
  - Drive req_ready[winner]=1 combinationally in the same cycle.
  - Latch req_data of the winner and its ID.
  - Next state is EXEC.
  - If no request is valid, stay in IDLE with req_ready all 0.
- EXEC:
  - Apply the latched operand to the incrementer.
  - Register sum = operand + 1 (4-bit wrap) and carry = &operand.
  - Next state is RESP.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_data and rsp_carry held stable.
  - On rsp_valid && rsp_ready: ptr = (winner+1) mod NREQ, next state is IDLE.
- req_ready is 0 in EXEC and RESP. No new operand is accepted while a transaction is in flight.
- A requester that drops req_valid before being granted is never granted; this is legal.
- Only one bit of req_ready is ever high.
- Wrap-around: operand 4'hF gives rsp_data 4'h0 and rsp_carry 1.
- Reset:
  - All outputs are 0, state is IDLE, ptr is 0, latched operand and ID are 0.
  - Asserting rst_n mid-transaction drops that transaction; no response is issued for it.

## Timing
- An accept in cycle T (req_valid && req_ready) puts the response out at T+2: rsp_valid is high from the first edge after EXEC.
- Minimum issue interval is 3 cycles when rsp_ready is held high.
- With rsp_ready low, the block remains in RESP indefinitely and the response fields do not change.
- The ptr update and the return to IDLE happen on the same edge as the response handshake.
- The next accept can occur in the cycle after the handshake.
- Simultaneous requests: ptr has priority, then ptr+1, and so on, wrapping modulo NREQ.
- req_ready has a combinational path from req_valid. Requesters must not make req_valid depend on req_ready.

## Configuration
- INC_ARB_FASTPATH_EN:
  - Defined: the EXEC state is removed. In IDLE, the incremented winner operand is registered directly and the FSM goes straight to RESP.
  - Defined: accept at T gives rsp_valid at T+1, and the minimum issue interval is 2 cycles.
  - Not defined: the 3-state behaviour above.
  - Handshake, round-robin order and reset behaviour are identical in both builds.

## Structure
- Shared package inc_arb_pkg holds:
  - FSM state encodings: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - Default NREQ and IDW constants.
- Sub-module rr_arbiter:
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, encoded grant ID, any_req.
  - Purely combinational.
- The top level owns the FSM, ptr, the operand/ID registers and the response registers.
- The increment itself is the plain 4-bit +1 datapath with carry-out = &operand.

## Test plan
- Reset: pulse rst_n low during EXEC → all outputs 0 immediately, busy 0, no rsp_valid afterwards, and the next grant goes to requester 0.
- Single request: req_valid=4'b0001 with requester 0 operand 4'h5, rsp_ready=1 → req_ready[0] pulses at T; rsp_valid at T+2 with id 0, data 4'h6, carry 0.
- Wrap-around: requester 2 operand 4'hF → rsp_id 2, rsp_data 4'h0, rsp_carry 1.
- Fairness: all four requesters held valid with rsp_ready=1 → grant order 0,1,2,3,0, with accepts every 3 cycles.
- Backpressure: rsp_ready low for 5 cycles during RESP → response fields stable, req_ready all 0, busy 1. Raising rsp_ready completes the handshake, and the next requester is accepted one cycle later.
- With INC_ARB_FASTPATH_EN defined: requester 1 operand 4'h9 → rsp_valid at T+1 with id 1 and data 4'hA. Continuous requests are accepted every 2 cycles.
